// File: rtl/demux_1_to_n_response_cache.sv
// demux_1_to_n_response_cache
//   Return path of the cache request arbiter. One response stream from the
//   cache is routed by requestor ID into one of NUM_MEMORY_REQUESTOR response
//   FIFOs. Each requestor pops its own FIFO. A single registered ready signal
//   back-pressures the cache once any FIFO reaches its prog_full threshold.
//
// Ports
//   ap_clk                    clock, all logic on the rising edge
//   areset                    synchronous active-high reset
//   response_in               response from cache (valid + payload)
//   response_in_ready         cache may present a response next cycle
//   fifo_response_signals_in  per-requestor rd_en
//   fifo_response_signals_out per-requestor {empty, prog_full}, registered
//   response_out              per-requestor response, registered
//   fifo_setup_signal         high while the FIFOs are in reset
//   error_count_out           dropped-response count (only with
//                             DEMUX_RESPONSE_ERROR_COUNT_EN defined)
//
// Optional feature macro: DEMUX_RESPONSE_ERROR_COUNT_EN

package demux_response_pkg;
  typedef struct packed { logic [7:0] id; } MemoryPacketRouteAttributes;
  typedef struct packed { MemoryPacketRouteAttributes route; } MemoryPacketMeta;
  typedef struct packed {
    MemoryPacketMeta meta;
    logic [31:0]     data;
  } MemoryPacketPayload;
  typedef struct packed {
    logic               valid;
    MemoryPacketPayload payload;
  } MemoryPacketResponse;
  typedef struct packed { logic rd_en; } FIFOStateSignalsInput;
  typedef struct packed {
    logic empty;
    logic prog_full;
  } FIFOStateSignalsOutput;
endpackage

module demux_1_to_n_response_cache
  import demux_response_pkg::*;
#(
  parameter int NUM_MEMORY_REQUESTOR = 2,
  parameter int ID_WIDTH = (NUM_MEMORY_REQUESTOR > 1) ? $clog2(NUM_MEMORY_REQUESTOR) : 1,
  parameter int FIFO_WRITE_DEPTH = 32,
  parameter int PROG_THRESH = 24
) (
  input  logic                                             ap_clk,
  input  logic                                             areset,
  input  MemoryPacketResponse                              response_in,
  output logic                                             response_in_ready,
  input  FIFOStateSignalsInput  [NUM_MEMORY_REQUESTOR-1:0] fifo_response_signals_in,
  output FIFOStateSignalsOutput [NUM_MEMORY_REQUESTOR-1:0] fifo_response_signals_out,
  output MemoryPacketResponse   [NUM_MEMORY_REQUESTOR-1:0] response_out,
  output logic                                             fifo_setup_signal
`ifdef DEMUX_RESPONSE_ERROR_COUNT_EN
  ,
  output logic [31:0]                                      error_count_out
`endif
);

  localparam int unsigned N_REQ = NUM_MEMORY_REQUESTOR;
  localparam int AW = (FIFO_WRITE_DEPTH > 1) ? $clog2(FIFO_WRITE_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [2:0] BUSY_CYCLES = 3'd4;

  typedef enum logic [1:0] {S_RESET, S_SETUP, S_READY} state_t;

  logic areset_control, areset_fifo, areset_demux;
  state_t state, state_next;
  logic [2:0] busy_cnt;
  logic rst_busy;

  MemoryPacketResponse in_reg;
  logic [31:0] id_full;
  logic [ID_WIDTH-1:0] route_idx;
  logic id_ok, push_ok;
  logic [NUM_MEMORY_REQUESTOR-1:0] hit_vec, full_vec, prog_full_vec;

  always_ff @(posedge ap_clk) begin
    areset_control <= areset;
    areset_fifo    <= areset;
    areset_demux   <= areset;
  end

  always_ff @(posedge ap_clk) begin
    if (areset_control) state <= S_RESET;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_RESET: state_next = S_SETUP;
      S_SETUP: if (!rst_busy) state_next = S_READY;
      S_READY: state_next = S_READY;
      default: state_next = S_RESET;
    endcase
  end

  // All FIFOs are flushed together, so one sequencer stands in for every
  // FIFO's wr_rst_busy/rd_rst_busy.
  always_ff @(posedge ap_clk) begin
    if (areset_fifo)            busy_cnt <= BUSY_CYCLES;
    else if (busy_cnt != '0)    busy_cnt <= busy_cnt - 3'd1;
  end
  assign rst_busy = areset_fifo | (busy_cnt != '0);

  always_ff @(posedge ap_clk) begin
    in_reg.payload <= response_in.payload;
    if (areset_demux) in_reg.valid <= 1'b0;
    else              in_reg.valid <= response_in.valid;
  end

  // FIFO index uses the low ID bits; validity uses the whole field so an
  // out-of-range ID can never alias onto a real requestor.
  assign id_full   = 32'(in_reg.payload.meta.route.id);
  assign route_idx = in_reg.payload.meta.route.id[ID_WIDTH-1:0];
  assign id_ok     = id_full < N_REQ;
  assign push_ok   = (state == S_READY) & in_reg.valid;

  for (genvar i = 0; i < NUM_MEMORY_REQUESTOR; i++) begin : g_fifo
    MemoryPacketPayload mem [FIFO_WRITE_DEPTH];
    MemoryPacketPayload dout;
    MemoryPacketResponse resp_q;
    FIFOStateSignalsOutput sig_q;
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count, count_next;
    logic empty, full, prog_full, wr_en, rd_en, rd_en_reg, fifo_valid;

    assign hit_vec[i]       = id_ok & (route_idx == ID_WIDTH'(i));
    assign full             = count == CW'(FIFO_WRITE_DEPTH);
    assign prog_full        = count >= CW'(PROG_THRESH);
    assign full_vec[i]      = full;
    assign prog_full_vec[i] = prog_full;
    assign wr_en            = push_ok & hit_vec[i] & ~full;
    assign rd_en            = ~empty & rd_en_reg;
    assign count_next       = count + CW'(wr_en) - CW'(rd_en);

    always_ff @(posedge ap_clk) begin
      if (wr_en) mem[wptr] <= in_reg.payload;
      if (rd_en) dout <= mem[rptr];
      rd_en_reg <= fifo_response_signals_in[i].rd_en;
    end

    // empty clears one cycle after the first write but sets immediately on
    // the last read, so it never reports data that is not there.
    always_ff @(posedge ap_clk) begin
      if (areset_fifo) begin
        wptr       <= '0;
        rptr       <= '0;
        count      <= '0;
        empty      <= 1'b1;
        fifo_valid <= 1'b0;
      end else begin
        if (wr_en) wptr <= wptr + AW'(1);
        if (rd_en) rptr <= rptr + AW'(1);
        count      <= count_next;
        empty      <= (count_next == '0) | (count == '0);
        fifo_valid <= rd_en;
      end
    end

    always_ff @(posedge ap_clk) begin
      resp_q.payload <= dout;
      if (areset_demux) begin
        resp_q.valid <= 1'b0;
        sig_q        <= 2'b10;
      end else begin
        resp_q.valid <= fifo_valid;
        sig_q        <= {empty, prog_full};
      end
    end

    assign response_out[i]              = resp_q;
    assign fifo_response_signals_out[i] = sig_q;
  end

  always_ff @(posedge ap_clk) begin
    if (areset_demux) begin
      response_in_ready <= 1'b0;
      fifo_setup_signal <= 1'b1;
    end else begin
      response_in_ready <= (state == S_READY) & ~|prog_full_vec;
      fifo_setup_signal <= rst_busy;
    end
  end

`ifdef DEMUX_RESPONSE_ERROR_COUNT_EN
  logic drop;
  logic [31:0] error_count;

  assign drop = push_ok & (~id_ok | |(full_vec & hit_vec));

  always_ff @(posedge ap_clk) begin
    if (areset_demux)                    error_count <= '0;
    else if (drop && (error_count != '1)) error_count <= error_count + 32'd1;
  end
  assign error_count_out = error_count;
`endif

endmodule
